// File: rtl/cipher_sequencer.sv
// Control sequencer for a serial key + message load, XOR encrypt and output stream transaction.
// Walks the loader deserializers, waits on the downstream stages, and traps stalls in ERROR.
module cipher_sequencer #(
  parameter int unsigned KEY_SIZE = 32,
  parameter int unsigned MSG_SIZE = 512,
  parameter int unsigned TIMEOUT  = 1023
) (
  input  logic       iClk,
  input  logic       iRst,
  input  logic       iStart,
  input  logic       iAbort,
  input  logic       iData_valid,
  input  logic       iSerial_in,
  input  logic       iEncrypt_done,
  input  logic       iSerial_end,
  output logic       oEn,
  output logic       oData_in,
  output logic       oLoad_key,
  output logic       oLoad_msg,
  output logic       oBusy,
  output logic       oDone,
  output logic       oError,
  output logic [2:0] oState
);

  localparam int unsigned BitW = $clog2(MSG_SIZE) + 1;
  localparam int unsigned TmoW = $clog2(TIMEOUT + 1);

  localparam logic [BitW-1:0] KeyLast = BitW'(KEY_SIZE - 1);
  localparam logic [BitW-1:0] MsgLast = BitW'(MSG_SIZE - 1);
  localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StLoadKey = 3'd1,
    StLoadMsg = 3'd2,
    StEncrypt = 3'd3,
    StStream  = 3'd4,
    StDone    = 3'd5,
    StError   = 3'd6
  } state_e;

  state_e          r_state;
  logic [BitW-1:0] r_bits;
  logic [TmoW-1:0] r_tmo;

  logic w_load;
  logic w_bit;
  logic w_waiting;
  logic w_last_bit;
  logic w_tmo_hit;

  assign w_load     = (r_state == StLoadKey) || (r_state == StLoadMsg);
  assign w_bit      = w_load && iData_valid;
  assign w_waiting  = w_load || (r_state == StEncrypt) || (r_state == StStream);
  assign w_last_bit = (r_state == StLoadKey) ? (r_bits == KeyLast) : (r_bits == MsgLast);
  // A valid bit is progress, so it masks a timeout landing in the same cycle.
  assign w_tmo_hit  = w_waiting && !w_bit && (r_tmo == TmoLast);

  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      r_state <= StIdle;
      r_bits  <= '0;
      r_tmo   <= '0;
    end else if (iAbort) begin
      r_state <= StIdle;
      r_bits  <= '0;
      r_tmo   <= '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          r_bits <= '0;
          r_tmo  <= '0;
          if (iStart) begin
            r_state <= StLoadKey;
          end
        end
        StLoadKey, StLoadMsg: begin
          if (iData_valid) begin
            r_tmo <= '0;
            if (w_last_bit) begin
              r_state <= (r_state == StLoadKey) ? StLoadMsg : StEncrypt;
              r_bits  <= '0;
            end else begin
              r_bits <= r_bits + 1'b1;
            end
          end else if (w_tmo_hit) begin
            r_state <= StError;
            r_bits  <= '0;
            r_tmo   <= '0;
          end else begin
            r_tmo <= r_tmo + 1'b1;
          end
        end
        StEncrypt: begin
          if (iEncrypt_done) begin
            r_state <= StStream;
            r_tmo   <= '0;
          end else if (w_tmo_hit) begin
            r_state <= StError;
            r_tmo   <= '0;
          end else begin
            r_tmo <= r_tmo + 1'b1;
          end
        end
        StStream: begin
          if (iSerial_end) begin
            r_state <= StDone;
            r_tmo   <= '0;
          end else if (w_tmo_hit) begin
            r_state <= StError;
            r_tmo   <= '0;
          end else begin
            r_tmo <= r_tmo + 1'b1;
          end
        end
        StDone: begin
          r_state <= StIdle;
        end
        StError: begin
          r_state <= StError;
        end
        default: begin
          r_state <= StIdle;
          r_bits  <= '0;
          r_tmo   <= '0;
        end
      endcase
    end
  end

  // Status flags decode straight from the state register so reset clears them at once.
  assign oEn       = w_bit;
  assign oData_in  = w_load && iSerial_in;
  assign oLoad_key = (r_state == StLoadKey);
  assign oLoad_msg = (r_state == StLoadMsg);
  assign oBusy     = (r_state != StIdle);
  assign oDone     = (r_state == StDone);
  assign oError    = (r_state == StError);
  assign oState    = r_state;

endmodule

// File: tb/tb_cipher_sequencer.sv
// Directed bench for cipher_sequencer with KEY_SIZE=4, MSG_SIZE=8, TIMEOUT=15.
module tb_cipher_sequencer;

  logic       iClk;
  logic       iRst;
  logic       iStart;
  logic       iAbort;
  logic       iData_valid;
  logic       iSerial_in;
  logic       iEncrypt_done;
  logic       iSerial_end;
  logic       oEn;
  logic       oData_in;
  logic       oLoad_key;
  logic       oLoad_msg;
  logic       oBusy;
  logic       oDone;
  logic       oError;
  logic [2:0] oState;

  int checks   = 0;
  int failures = 0;

  cipher_sequencer #(
    .KEY_SIZE(4),
    .MSG_SIZE(8),
    .TIMEOUT (15)
  ) dut (
    .iClk         (iClk),
    .iRst         (iRst),
    .iStart       (iStart),
    .iAbort       (iAbort),
    .iData_valid  (iData_valid),
    .iSerial_in   (iSerial_in),
    .iEncrypt_done(iEncrypt_done),
    .iSerial_end  (iSerial_end),
    .oEn          (oEn),
    .oData_in     (oData_in),
    .oLoad_key    (oLoad_key),
    .oLoad_msg    (oLoad_msg),
    .oBusy        (oBusy),
    .oDone        (oDone),
    .oError       (oError),
    .oState       (oState)
  );

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  task automatic tick();
    @(posedge iClk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_st(input string tag, input logic [2:0] exp);
    checks++;
    assert (oState === exp)
    else begin
      failures++;
      $error("FAIL %s observed_state=%0d expected_state=%0d", tag, oState, exp);
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk_st({tag, "_state"}, 3'd0);
    chk1({tag, "_busy"}, oBusy, 1'b0);
    chk1({tag, "_done"}, oDone, 1'b0);
    chk1({tag, "_error"}, oError, 1'b0);
    chk1({tag, "_load_key"}, oLoad_key, 1'b0);
    chk1({tag, "_load_msg"}, oLoad_msg, 1'b0);
    chk1({tag, "_en"}, oEn, 1'b0);
    chk1({tag, "_data_in"}, oData_in, 1'b0);
  endtask

  task automatic send_bit(input logic b);
    iData_valid = 1'b1;
    iSerial_in  = b;
    tick();
    iData_valid = 1'b0;
    iSerial_in  = 1'b0;
  endtask

  task automatic start_txn();
    iStart = 1'b1;
    tick();
    iStart = 1'b0;
  endtask

  task automatic abort_txn();
    iAbort = 1'b1;
    tick();
    iAbort = 1'b0;
  endtask

  initial begin
    logic [3:0] key;
    logic [7:0] msg;
    key = 4'b1011;
    msg = 8'hA5;

    iRst = 1'b0; iStart = 1'b0; iAbort = 1'b0; iData_valid = 1'b1; iSerial_in = 1'b1;
    iEncrypt_done = 1'b0; iSerial_end = 1'b0;
    #3;
    chk_quiet("reset");
    iData_valid = 1'b0; iSerial_in = 1'b0;
    tick();
    tick();
    iRst = 1'b1;
    tick();
    chk_quiet("post_reset");

    // Nominal transaction
    start_txn();
    chk_st("nom_load_key", 3'd1);
    chk1("nom_load_key_flag", oLoad_key, 1'b1);
    chk1("nom_busy", oBusy, 1'b1);
    for (int i = 0; i < 4; i++) begin
      iData_valid = 1'b1;
      iSerial_in  = key[3-i];
      #1;
      chk1("nom_key_en", oEn, 1'b1);
      chk1("nom_key_data", oData_in, key[3-i]);
      if (i == 3) chk1("nom_key_flag_last", oLoad_key, 1'b1);
      tick();
    end
    iData_valid = 1'b0;
    iSerial_in  = 1'b0;
    chk_st("nom_load_msg", 3'd2);
    chk1("nom_load_msg_flag", oLoad_msg, 1'b1);
    chk1("nom_key_flag_off", oLoad_key, 1'b0);
    for (int i = 0; i < 8; i++) send_bit(msg[7-i]);
    chk_st("nom_encrypt", 3'd3);
    chk1("nom_msg_flag_off", oLoad_msg, 1'b0);

    // Stray strobes in ENCRYPT are dropped
    iData_valid = 1'b1; iSerial_in = 1'b1; iSerial_end = 1'b1;
    #1;
    chk1("encrypt_en_masked", oEn, 1'b0);
    chk1("encrypt_data_masked", oData_in, 1'b0);
    tick();
    iData_valid = 1'b0; iSerial_in = 1'b0; iSerial_end = 1'b0;
    chk_st("encrypt_ignores_end", 3'd3);

    iEncrypt_done = 1'b1;
    tick();
    iEncrypt_done = 1'b0;
    chk_st("nom_stream", 3'd4);
    start_txn();
    chk_st("stream_ignores_start", 3'd4);
    iSerial_end = 1'b1;
    tick();
    iSerial_end = 1'b0;
    chk_st("nom_done", 3'd5);
    chk1("nom_done_pulse", oDone, 1'b1);
    tick();
    chk_st("nom_back_idle", 3'd0);
    chk1("nom_done_one_cycle", oDone, 1'b0);

    // Gapped data: 3 idle cycles between bits, no timeout
    start_txn();
    for (int i = 0; i < 4; i++) begin
      send_bit(key[3-i]);
      if (i == 2) chk_st("gap_still_key", 3'd1);
      if (i == 3) chk_st("gap_key_to_msg", 3'd2);
      if (i < 3) begin
        tick(); tick(); tick();
      end
    end
    chk1("gap_no_error", oError, 1'b0);
    abort_txn();
    chk_st("gap_abort", 3'd0);

    // Valid bit on the timeout cycle counts as progress
    start_txn();
    for (int i = 0; i < 14; i++) tick();
    chk_st("tmo_edge_pre", 3'd1);
    send_bit(1'b1);
    chk_st("tmo_edge_progress", 3'd1);
    send_bit(1'b0);
    send_bit(1'b1);
    chk_st("tmo_edge_bit3", 3'd1);
    send_bit(1'b1);
    chk_st("tmo_edge_bit_counted", 3'd2);
    abort_txn();

    // Timeout into ERROR, held until abort
    start_txn();
    for (int i = 0; i < 14; i++) tick();
    chk_st("tmo_not_yet", 3'd1);
    tick();
    chk_st("tmo_error", 3'd6);
    chk1("tmo_error_flag", oError, 1'b1);
    chk1("tmo_error_busy", oBusy, 1'b1);
    start_txn();
    chk_st("error_held", 3'd6);
    abort_txn();
    chk_st("error_abort", 3'd0);
    chk1("error_cleared", oError, 1'b0);

    // Abort mid LOAD_MSG then restart from a cleared counter
    start_txn();
    for (int i = 0; i < 4; i++) send_bit(key[3-i]);
    for (int i = 0; i < 5; i++) send_bit(msg[7-i]);
    chk_st("abort_in_msg", 3'd2);
    abort_txn();
    chk_st("abort_idle", 3'd0);
    start_txn();
    chk_st("restart_key", 3'd1);
    for (int i = 0; i < 3; i++) send_bit(1'b1);
    chk_st("restart_cnt_zero", 3'd1);
    send_bit(1'b1);
    chk_st("restart_key_done", 3'd2);
    abort_txn();

    // Abort wins over start in IDLE
    iAbort = 1'b1; iStart = 1'b1;
    tick();
    iAbort = 1'b0; iStart = 1'b0;
    chk_st("abort_over_start", 3'd0);

    // Asynchronous reset between edges while in ENCRYPT
    start_txn();
    for (int i = 0; i < 4; i++) send_bit(key[3-i]);
    for (int i = 0; i < 8; i++) send_bit(msg[7-i]);
    chk_st("areset_in_encrypt", 3'd3);
    iData_valid = 1'b1; iSerial_in = 1'b1;
    #2;
    iRst = 1'b0;
    #1;
    chk_quiet("areset");
    iData_valid = 1'b0; iSerial_in = 1'b0;
    tick();
    iRst = 1'b1;
    iEncrypt_done = 1'b1; iSerial_end = 1'b1;
    tick();
    iEncrypt_done = 1'b0; iSerial_end = 1'b0;
    chk_st("areset_needs_start", 3'd0);
    start_txn();
    chk_st("areset_restart", 3'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
